// File: rtl/phv_reassemble_if.sv
// phv_reassemble_if: ALU result bundle in, reassembled PHV out, with valid/ready on both sides.
// master = upstream ALUs plus downstream consumer; slave = the reassembly block.
interface phv_reassemble_if #(
  parameter int unsigned PHV_LEN    = 4*8*64+256,
  parameter int unsigned width_4B   = 32,
  parameter int unsigned C_NUM_CONT = 64
);
  localparam int unsigned RemainW = PHV_LEN - width_4B*C_NUM_CONT;

  logic                           alu_out_valid;
  logic [width_4B*C_NUM_CONT-1:0] alu_out_4B;
  logic [RemainW-1:0]             phv_remain_in;
  logic                           ready_out;
  logic [PHV_LEN-1:0]             phv_out;
  logic                           phv_out_valid;
  logic                           ready_in;
  logic [31:0]                    phv_count;
  logic                           overflow;

  modport master (
    output alu_out_valid, alu_out_4B, phv_remain_in, ready_in,
    input  ready_out, phv_out, phv_out_valid, phv_count, overflow
  );

  modport slave (
    input  alu_out_valid, alu_out_4B, phv_remain_in, ready_in,
    output ready_out, phv_out, phv_out_valid, phv_count, overflow
  );
endinterface

// File: rtl/phv_reassemble.sv
// phv_reassemble: packs 64 ALU container results plus the metadata tail back into a PHV and
// queues it in a 2-entry FIFO toward the next stage. Tracks popped PHVs and sticky overflow.
module phv_reassemble #(
  parameter int          STAGE_ID   = 0,
  parameter int unsigned PHV_LEN    = 4*8*64+256,
  parameter int unsigned width_4B   = 32,
  parameter int unsigned C_NUM_CONT = 64
) (
  input logic             clk,
  input logic             rst,
  phv_reassemble_if.slave bus
);
  localparam int unsigned ContW   = width_4B*C_NUM_CONT;
  localparam int unsigned RemainW = PHV_LEN - ContW;

  if (STAGE_ID < 0 || PHV_LEN <= ContW) begin : g_bad_param
    $error("phv_reassemble: bad STAGE_ID or PHV_LEN too small for the containers");
  end

  logic               w_push;
  logic               w_pop;
  logic [1:0]         r_count;
  logic [1:0]         w_count_d;
  logic               r_wr_ptr;
  logic               r_rd_ptr;
  logic               w_rd_ptr_d;
  logic [PHV_LEN-1:0] w_packed;
  logic [PHV_LEN-1:0] w_head_d;
  logic [PHV_LEN-1:0] r_mem [2];
  logic [PHV_LEN-1:0] r_phv_out;
  logic               r_phv_out_valid;
  logic               r_ready_out;
  logic [31:0]        r_phv_count;
  logic               r_overflow;

  // Bundles arriving while not ready are dropped; only accepted ones touch the FIFO.
  assign w_push     = bus.alu_out_valid & r_ready_out;
  assign w_pop      = r_phv_out_valid & bus.ready_in;
  assign w_count_d  = r_count + {1'b0, w_push} - {1'b0, w_pop};
  assign w_rd_ptr_d = r_rd_ptr ^ w_pop;

  // Gather container i into its PHV slot; container 63 lands in the MSBs, tail in the LSBs.
  always_comb begin
    w_packed = '0;
    for (int i = 0; i < int'(C_NUM_CONT); i++) begin
      w_packed[PHV_LEN-1 - width_4B*(C_NUM_CONT-1-i) -: width_4B] =
        bus.alu_out_4B[(i+1)*width_4B-1 -: width_4B];
    end
    w_packed[RemainW-1:0] = bus.phv_remain_in;
  end

  // Next head: bypass the incoming bundle when it is written to the slot about to be read.
  always_comb begin
    w_head_d = r_mem[w_rd_ptr_d];
    if (w_push && (r_wr_ptr == w_rd_ptr_d)) begin
      w_head_d = w_packed;
    end
  end

  // FIFO storage; contents are don't-care after reset so no reset is applied.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_packed;
    end
  end

  // Pointers, occupancy and the registered ready/valid flags derived from next occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr        <= 1'b0;
      r_rd_ptr        <= 1'b0;
      r_count         <= 2'd0;
      r_ready_out     <= 1'b1;
      r_phv_out_valid <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= ~r_wr_ptr;
      end
      r_rd_ptr        <= w_rd_ptr_d;
      r_count         <= w_count_d;
      r_ready_out     <= (w_count_d != 2'd2);
      r_phv_out_valid <= (w_count_d != 2'd0);
    end
  end

  // Output register tracks the head; it keeps its last value once the FIFO drains.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_phv_out <= '0;
    end else if (w_count_d != 2'd0) begin
      r_phv_out <= w_head_d;
    end
  end

  // Popped-PHV counter (wraps) and sticky overflow on a bundle offered while not ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_phv_count <= 32'd0;
      r_overflow  <= 1'b0;
    end else begin
      if (w_pop) begin
        r_phv_count <= r_phv_count + 32'd1;
      end
      if (bus.alu_out_valid && !r_ready_out) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign bus.ready_out     = r_ready_out;
  assign bus.phv_out       = r_phv_out;
  assign bus.phv_out_valid = r_phv_out_valid;
  assign bus.phv_count     = r_phv_count;
  assign bus.overflow      = r_overflow;
endmodule

// File: tb/tb_phv_reassemble.sv
// tb_phv_reassemble: randomized and directed stimulus; a predictor queues expected PHVs as
// bundles are offered, a separate monitor pops and compares whenever the DUT hands one off.
module tb_phv_reassemble;
  localparam int unsigned PhvLen  = 2304;
  localparam int unsigned ContW   = 2048;
  localparam int unsigned RemW    = 256;
  localparam int unsigned MaxWait = 1000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  phv_reassemble_if bus_if ();

  phv_reassemble dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  int unsigned       n_checks = 0;
  int unsigned       n_pass   = 0;
  int unsigned       cyc      = 0;
  logic [PhvLen-1:0] exp_q [$];
  logic              model_ovf;
  logic [31:0]       pop_cnt;
  logic              hold_prev;
  logic [PhvLen-1:0] prev_phv;
  bit                rand_ready = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  task automatic check_phv(input string name, input logic [PhvLen-1:0] act,
                           input logic [PhvLen-1:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else begin
      int w;
      w = 0;
      for (int i = PhvLen/32-1; i >= 0; i--) begin
        if (act[i*32 +: 32] !== req[i*32 +: 32]) w = i;
      end
      $display("FAIL %s: word %0d got 0x%08h, expected 0x%08h", name, w,
               act[w*32 +: 32], req[w*32 +: 32]);
    end
  endtask

  // Reference packing: container 63 is the most significant word, tail sits below container 0.
  function automatic logic [PhvLen-1:0] pack(input logic [ContW-1:0] alu,
                                             input logic [RemW-1:0] rem);
    return {alu, rem};
  endfunction

  function automatic logic [ContW-1:0] rand_alu();
    logic [ContW-1:0] v;
    for (int i = 0; i < 64; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [RemW-1:0] rand_rem();
    logic [RemW-1:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Predictor: occupancy model decides acceptance; accepted bundles are queued as expected PHVs.
  always @(negedge clk) begin
    if (!rst) begin
      check("ready_out", 64'(bus_if.ready_out), 64'(exp_q.size() < 2));
      check("phv_out_valid", 64'(bus_if.phv_out_valid), 64'(exp_q.size() != 0));
      check("overflow", 64'(bus_if.overflow), 64'(model_ovf));
      if (bus_if.alu_out_valid) begin
        if (exp_q.size() < 2) exp_q.push_back(pack(bus_if.alu_out_4B, bus_if.phv_remain_in));
        else model_ovf = 1'b1;
      end
    end
  end

  // Monitor: on every handoff compare against the oldest expected PHV; check stall stability.
  always @(negedge clk) begin
    #1;
    if (!rst) begin
      check("phv_count", 64'(bus_if.phv_count), 64'(pop_cnt));
      if (hold_prev) check_phv("stall stable", bus_if.phv_out, prev_phv);
      if (bus_if.phv_out_valid && bus_if.ready_in) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL pop order: got output word0 0x%08h, expected no output",
                   bus_if.phv_out[31:0]);
        end else begin
          check_phv("pop data", bus_if.phv_out, exp_q.pop_front());
        end
        pop_cnt = pop_cnt + 32'd1;
      end
      hold_prev = bus_if.phv_out_valid && !bus_if.ready_in;
      prev_phv  = bus_if.phv_out;
    end else begin
      hold_prev = 1'b0;
    end
  end

  // Random downstream backpressure during the random phase.
  always @(posedge clk) begin
    if (rand_ready) begin
      #1;
      bus_if.ready_in = 1'($urandom_range(1));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Well-behaved upstream: keep the bundle, offer it only while ready_out is high.
  task automatic send(input logic [ContW-1:0] alu, input logic [RemW-1:0] rem);
    int unsigned waited;
    waited = 0;
    bus_if.alu_out_4B    = alu;
    bus_if.phv_remain_in = rem;
    while (!bus_if.ready_out && waited < MaxWait) begin
      bus_if.alu_out_valid = 1'b0;
      tick();
      waited++;
    end
    if (bus_if.ready_out) begin
      bus_if.alu_out_valid = 1'b1;
      tick();
      bus_if.alu_out_valid = 1'b0;
    end else begin
      n_checks++;
      $display("FAIL send timeout: ready_out got 0 for %0d cycles, expected 1", MaxWait);
    end
  endtask

  // Offer a bundle for exactly one cycle regardless of ready_out.
  task automatic send_once(input logic [ContW-1:0] alu, input logic [RemW-1:0] rem);
    bus_if.alu_out_4B    = alu;
    bus_if.phv_remain_in = rem;
    bus_if.alu_out_valid = 1'b1;
    tick();
    bus_if.alu_out_valid = 1'b0;
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear before any clock edge.
  task automatic do_reset();
    #2;
    rst = 1'b1;
    exp_q.delete();
    model_ovf = 1'b0;
    pop_cnt   = 32'd0;
    #1;
    check_phv("reset phv_out", bus_if.phv_out, '0);
    check("reset phv_out_valid", 64'(bus_if.phv_out_valid), 64'd0);
    check("reset ready_out", 64'(bus_if.ready_out), 64'd1);
    check("reset phv_count", 64'(bus_if.phv_count), 64'd0);
    check("reset overflow", 64'(bus_if.overflow), 64'd0);
    bus_if.alu_out_valid = 1'b0;
    bus_if.ready_in      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    check("post-reset phv_out_valid", 64'(bus_if.phv_out_valid), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [ContW-1:0] a;
    logic [ContW-1:0] b;
    logic [ContW-1:0] c;
    int unsigned      t0;

    rst                  = 1'b1;
    model_ovf            = 1'b0;
    pop_cnt              = 32'd0;
    hold_prev            = 1'b0;
    bus_if.alu_out_valid = 1'b0;
    bus_if.alu_out_4B    = '0;
    bus_if.phv_remain_in = '0;
    bus_if.ready_in      = 1'b0;
    tick();
    do_reset();

    // Packing
    bus_if.ready_in = 1'b1;
    for (int i = 0; i < 64; i++) a[i*32 +: 32] = 32'hA500_0000 + 32'(i);
    send(a, 256'h1234);
    check("pack valid", 64'(bus_if.phv_out_valid), 64'd1);
    check("pack container63", 64'(bus_if.phv_out[2303:2272]), 64'hA500_003F);
    check("pack container0", 64'(bus_if.phv_out[287:256]), 64'hA500_0000);
    check("pack tail low", bus_if.phv_out[63:0], 64'h1234);
    check("pack tail high zero", 64'(|bus_if.phv_out[255:64]), 64'd0);

    // Streaming
    do_reset();
    bus_if.ready_in = 1'b1;
    t0 = cyc;
    for (int s = 0; s < 100; s++) begin
      a = rand_alu();
      a[31:0] = 32'(s);
      send(a, rand_rem());
    end
    check("stream cycles", 64'(cyc - t0), 64'd100);
    tick();
    check("stream phv_count", 64'(bus_if.phv_count), 64'd100);

    // Backpressure and violation
    do_reset();
    a = rand_alu(); a[31:0] = 32'h0000_AAAA;
    b = rand_alu(); b[31:0] = 32'h0000_BBBB;
    c = rand_alu(); c[31:0] = 32'h0000_CCCC;
    send(a, rand_rem());
    send(b, rand_rem());
    check("bp ready_out after B", 64'(bus_if.ready_out), 64'd0);
    send_once(c, rand_rem());
    check("overflow set", 64'(bus_if.overflow), 64'd1);
    tick();
    check("overflow sticky", 64'(bus_if.overflow), 64'd1);
    bus_if.ready_in = 1'b1;
    tick();
    check("bp ready_out after A pop", 64'(bus_if.ready_out), 64'd1);
    check("bp head is B", 64'(bus_if.phv_out[287:256]), 64'h0000_BBBB);
    tick();
    check("bp drained", 64'(bus_if.phv_out_valid), 64'd0);
    check("overflow still set", 64'(bus_if.overflow), 64'd1);

    // Counter wrap and simultaneous push/pop at one entry
    do_reset();
    force dut.r_phv_count = 32'hFFFF_FFFF;
    pop_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.r_phv_count;
    a = rand_alu(); a[31:0] = 32'h0000_1111;
    b = rand_alu(); b[31:0] = 32'h0000_2222;
    send(a, rand_rem());
    bus_if.ready_in = 1'b1;
    send_once(b, rand_rem());
    check("wrap phv_count", 64'(bus_if.phv_count), 64'd0);
    check("simul valid", 64'(bus_if.phv_out_valid), 64'd1);
    check("simul head is second", 64'(bus_if.phv_out[287:256]), 64'h0000_2222);
    check("simul ready_out", 64'(bus_if.ready_out), 64'd1);
    tick();
    check("simul drained", 64'(bus_if.phv_out_valid), 64'd0);
    check("post-wrap phv_count", 64'(bus_if.phv_count), 64'd1);

    // Random traffic with random backpressure
    do_reset();
    rand_ready = 1'b1;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(3) == 0) tick();
      send(rand_alu(), rand_rem());
    end
    rand_ready = 1'b0;
    tick();
    bus_if.ready_in = 1'b1;
    repeat (4) tick();
    check("random drain empty", 64'(exp_q.size()), 64'd0);
    check("random no overflow", 64'(bus_if.overflow), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
